seq_restoring_divider: RTL and testbench

//  Sequential unsigned restoring divider; inverse of the team's 5x5 multipliers.

---
 rtl/div_pkg.sv | 18 +
 rtl/seq_restoring_divider_if.sv | 30 +++
 rtl/div_step.sv | 24 ++
 rtl/seq_restoring_divider.sv | 127 ++++++++++++
 tb/tb_seq_restoring_divider.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential restoring divider.
// Optional fast divide-by-zero path is selected with DIV_ZERO_FAST_EN.
package div_pkg;

    localparam int WA_DEF = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must be able to hold NSTEP itself, hence the +1.
    function automatic int cnt_width(input int wa);
        return $clog2(2 * wa + 1);
    endfunction

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Start/result handshake bundle between a requester and the divider.
// odivz exists only when DIV_ZERO_FAST_EN is defined.
interface seq_restoring_divider_if
    import div_pkg::*;
#(
    parameter int WA = WA_DEF
);

    // Handshake: istart is taken on a rising edge only while oready=1, and ia/ib
    // are captured on that same edge. oready stays low until the result has been
    // presented. ovalid is a one-cycle pulse; oquot/orem (and odivz) then hold
    // until the next completion. Nothing is queued while oready=0.
    logic            istart;
    logic [2*WA-1:0] ia;
    logic [WA-1:0]   ib;
    logic            oready;
    logic            ovalid;
    logic [2*WA-1:0] oquot;
    logic [WA-1:0]   orem;
`ifdef DIV_ZERO_FAST_EN
    logic            odivz;

    modport master (output istart, ia, ib, input oready, ovalid, oquot, orem, odivz);
    modport slave  (input istart, ia, ib, output oready, ovalid, oquot, orem, odivz);
`else
    modport master (output istart, ia, ib, input oready, ovalid, oquot, orem);
    modport slave  (input istart, ia, ib, output oready, ovalid, oquot, orem);
`endif

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, subtract if it fits.
module div_step #(
    parameter int WA = 5
) (
    input  logic [WA:0]   rem,
    input  logic          din,
    input  logic [WA-1:0] divisor,
    output logic [WA:0]   rem_next,
    output logic          qbit
);

    logic [WA+1:0] shifted;
    logic [WA+1:0] ext_div;

    // rem[WA] is only ever set with a zero divisor; keeping it in the compare
    // leaves that case unchanged (always subtract 0) after truncation.
    always_comb begin
        shifted  = {rem, din};
        ext_div  = {2'b00, divisor};
        qbit     = (shifted >= ext_div);
        rem_next = qbit ? (WA + 1)'(shifted - ext_div) : shifted[WA:0];
    end

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Define DIV_ZERO_FAST_EN for the odivz flag and the single-cycle zero-divisor path.
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int WA = WA_DEF
) (
    input  logic                   iclk,
    input  logic                   irst_n,
    seq_restoring_divider_if.slave bus,
    output state_t                 dbg_state
);

    localparam int NSTEP = 2 * WA;
    localparam int CNT_W = cnt_width(WA);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NSTEP - 1);

    state_t          state;
    state_t          state_next;
    logic [CNT_W-1:0] cnt;
    logic [2*WA-1:0] dvd;
    logic [WA-1:0]   dvs;
    logic [WA:0]     rem;
    logic [WA:0]     rem_next;
    logic            qbit;
    logic            accept;
    logic            last_step;
    logic [2*WA-1:0] quot_q;
    logic [WA-1:0]   rem_q;
`ifdef DIV_ZERO_FAST_EN
    logic            zero_fast;
    logic            divz_q;

    assign zero_fast = (bus.ib == '0);
`endif

    assign accept    = (state == IDLE) && bus.istart;
    assign last_step = (cnt == LAST_STEP);

    div_step #(.WA(WA)) u_step (
        .rem      (rem),
        .din      (dvd[2*WA-1]),
        .divisor  (dvs),
        .rem_next (rem_next),
        .qbit     (qbit)
    );

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.istart) begin
`ifdef DIV_ZERO_FAST_EN
                    state_next = zero_fast ? DONE : BUSY;
`else
                    state_next = BUSY;
`endif
                end
            end
            BUSY:    if (last_step) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.oready = 1'b0;
        bus.ovalid = 1'b0;
        case (state)
            IDLE:    bus.oready = 1'b1;
            DONE:    bus.ovalid = 1'b1;
            default: ;
        endcase
    end

    // dvd doubles as the quotient register: dividend bits leave at the top
    // while quotient bits enter at the bottom.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            cnt    <= '0;
            dvd    <= '0;
            dvs    <= '0;
            rem    <= '0;
            quot_q <= '0;
            rem_q  <= '0;
`ifdef DIV_ZERO_FAST_EN
            divz_q <= 1'b0;
`endif
        end else if (accept) begin
            dvd <= bus.ia;
            dvs <= bus.ib;
            rem <= '0;
            cnt <= '0;
`ifdef DIV_ZERO_FAST_EN
            if (zero_fast) begin
                quot_q <= '1;
                rem_q  <= bus.ia[WA-1:0];
                divz_q <= 1'b1;
            end
`endif
        end else if (state == BUSY) begin
            dvd <= {dvd[2*WA-2:0], qbit};
            rem <= rem_next;
            cnt <= cnt + 1'b1;
            if (last_step) begin
                quot_q <= {dvd[2*WA-2:0], qbit};
                rem_q  <= rem_next[WA-1:0];
`ifdef DIV_ZERO_FAST_EN
                divz_q <= 1'b0;
`endif
            end
        end
    end

    assign bus.oquot = quot_q;
    assign bus.orem  = rem_q;
`ifdef DIV_ZERO_FAST_EN
    assign bus.odivz = divz_q;
`endif
    assign dbg_state = state;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: directed table, corner sequences,
// mult->divide round-trip sweep and random operands against an arithmetic model.
module tb_seq_restoring_divider;
    import div_pkg::*;

    localparam int WA    = 5;
    localparam int NSTEP = 2 * WA;
`ifdef DIV_ZERO_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic   iclk;
    logic   irst_n;
    state_t dbg_state;

    seq_restoring_divider_if #(.WA(WA)) bus ();

    seq_restoring_divider #(.WA(WA)) dut (
        .iclk      (iclk),
        .irst_n    (irst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    // scoreboard
    logic [3*WA-1:0] exp_q[$];
    int passed = 0;
    int total  = 0;
    int last_quot = 0;

    typedef struct {
        int a;
        int b;
        int quot;
        int rem;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    endtask

    // Reference: plain integer division; a zero divisor yields all-ones and the dividend's low bits.
    function automatic logic [3*WA-1:0] model(input int a, input int b);
        int q;
        int r;
        if (b == 0) begin
            q = (1 << (2 * WA)) - 1;
            r = a % (1 << WA);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q[2*WA-1:0], r[WA-1:0]};
    endfunction

    task automatic run_op(input int a, input int b, input int eq, input int er);
        int n;
        int lat;
        logic [3*WA-1:0] want;
        lat = (FAST && b == 0) ? 0 : NSTEP;
        n = 0;
        while (!bus.oready && n < 40) begin
            @(negedge iclk);
            n++;
        end
        check("idle_before_start", 32'(bus.oready), 32'd1);
        exp_q.push_back({eq[2*WA-1:0], er[WA-1:0]});
        bus.ia     = a[2*WA-1:0];
        bus.ib     = b[WA-1:0];
        bus.istart = 1'b1;
        @(posedge iclk);
        @(negedge iclk);
        bus.istart = 1'b0;
        bus.ia     = (2*WA)'($urandom);
        bus.ib     = WA'($urandom);
        if (lat != 0) begin
            check("busy_after_accept", 32'(bus.oready), 32'd0);
            check("hold_on_start", 32'(bus.oquot), 32'(last_quot));
        end
        n = 0;
        while (!bus.ovalid && n < 40) begin
            @(negedge iclk);
            n++;
        end
        check("latency", 32'(n), 32'(lat));
        if (exp_q.size() == 0) begin
            check("queue_nonempty", 32'd0, 32'd1);
        end else begin
            want = exp_q.pop_front();
            check("quot", 32'(bus.oquot), 32'(want[3*WA-1:WA]));
            check("rem", 32'(bus.orem), 32'(want[WA-1:0]));
        end
`ifdef DIV_ZERO_FAST_EN
        check("divz", 32'(bus.odivz), 32'(b == 0));
`endif
        last_quot = eq;
        @(negedge iclk);
        check("valid_width", 32'(bus.ovalid), 32'd0);
        check("ready_after_done", 32'(bus.oready), 32'd1);
        check("result_stable", 32'(bus.oquot), 32'(eq));
    endtask

    initial begin
        int lows;
        int accepts;
        int valids;
        int r;
        int a;
        int b;
        logic prev_ready;
        logic seen;
        logic [3*WA-1:0] m;

        vecs[0] = '{a: 1023, b: 31, quot: 33,   rem: 0};
        vecs[1] = '{a: 100,  b: 7,  quot: 14,   rem: 2};
        vecs[2] = '{a: 0,    b: 5,  quot: 0,    rem: 0};
        vecs[3] = '{a: 1023, b: 1,  quot: 1023, rem: 0};
        vecs[4] = '{a: 37,   b: 0,  quot: 1023, rem: 5};
        vecs[5] = '{a: 200,  b: 9,  quot: 22,   rem: 2};
        vecs[6] = '{a: 961,  b: 31, quot: 31,   rem: 0};
        vecs[7] = '{a: 1000, b: 3,  quot: 333,  rem: 1};

        irst_n     = 1'b0;
        bus.istart = 1'b0;
        bus.ia     = '0;
        bus.ib     = '0;
        repeat (2) @(negedge iclk);
        check("rst_oready", 32'(bus.oready), 32'd1);
        check("rst_ovalid", 32'(bus.ovalid), 32'd0);
        check("rst_oquot", 32'(bus.oquot), 32'd0);
        check("rst_orem", 32'(bus.orem), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
`ifdef DIV_ZERO_FAST_EN
        check("rst_odivz", 32'(bus.odivz), 32'd0);
`endif
        irst_n = 1'b1;
        @(negedge iclk);

        // directed table
        for (int i = 0; i < 8; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].quot, vecs[i].rem);

        // istart held high: one result per accept, 11 busy cycles between accepts
        bus.ia     = 10'd100;
        bus.ib     = 5'd7;
        bus.istart = 1'b1;
        lows = 0;
        accepts = 0;
        valids = 0;
        prev_ready = 1'b1;
        for (int i = 1; i <= 36; i++) begin
            @(negedge iclk);
            if (bus.ovalid) begin
                valids++;
                check("held_quot", 32'(bus.oquot), 32'd14);
                check("held_rem", 32'(bus.orem), 32'd2);
            end
            if (!bus.oready) lows++;
            else if (lows != 0) begin
                check("busy_cycles", 32'(lows), 32'd11);
                lows = 0;
            end
            if (prev_ready && !bus.oready) accepts++;
            prev_ready = bus.oready;
            if (i == 30) bus.istart = 1'b0;
        end
        check("held_accepts", 32'(accepts), 32'd3);
        check("held_valids", 32'(valids), 32'd3);
        last_quot = 14;

        // reset during step 4 of 200/9 aborts the operation
        bus.ia     = 10'd200;
        bus.ib     = 5'd9;
        bus.istart = 1'b1;
        @(posedge iclk);
        @(negedge iclk);
        bus.istart = 1'b0;
        repeat (4) @(negedge iclk);
        check("pre_abort_busy", 32'(dbg_state), 32'(BUSY));
        irst_n = 1'b0;
        #1;
        check("abort_oquot", 32'(bus.oquot), 32'd0);
        check("abort_orem", 32'(bus.orem), 32'd0);
        check("abort_oready", 32'(bus.oready), 32'd1);
        check("abort_ovalid", 32'(bus.ovalid), 32'd0);
        @(negedge iclk);
        irst_n = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            @(negedge iclk);
            if (bus.ovalid) seen = 1'b1;
        end
        check("no_valid_after_abort", 32'(seen), 32'd0);
        last_quot = 0;
        run_op(200, 9, 22, 2);

        // round trip: dividend = a*b (+ r < b), divisor b
        for (int ai = 0; ai < 32; ai++) begin
            for (int bi = 1; bi < 32; bi++) begin
                run_op(ai * bi, bi, ai, 0);
                r = $urandom_range(0, bi - 1);
                run_op(ai * bi + r, bi, ai, r);
            end
        end

        // fully random operands, zero divisor included
        for (int i = 0; i < 60; i++) begin
            a = $urandom_range(0, 1023);
            b = $urandom_range(0, 31);
            m = model(a, b);
            run_op(a, b, int'(m[3*WA-1:WA]), int'(m[WA-1:0]));
        end

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
